axis_ifft_channel_arbiter: RTL and testbench
============================================

Name: axis_ifft_channel_arbiter

Overview:
- Shares one 8-point IFFT core (512-bit spectrum in, 64-bit real samples out, fixed 4-stage pipeline that stalls as a whole on its own tready) between NUM_CH AXI-Stream requesters.
- Grants input beats round-robin, one beat per grant.
- Records the granted channel in an in-order tag FIFO.
- Steers each core output beat back to the channel that issued it. Sits between the per-channel spectrum sources and the shared core.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- CH_W, 2, channel index width; must equal clog2(NUM_CH).
- C_AXIS_TDATA_WIDTH, 512, spectrum beat width.
- C_AXIS_TOUT_WIDTH, 64, time-domain beat width.
- TAG_DEPTH, 8, tag FIFO entries, power of two, at least 5.

Ports:
- s_axis_aclk  in  1  clock for all logic
- s_axis_areset  in  1  asynchronous active-high reset
- s_tvalid  in  NUM_CH  per-channel spectrum valid
- s_tready  out  NUM_CH  per-channel spectrum ready
- s_tdata  in  NUM_CH*C_AXIS_TDATA_WIDTH  channel i occupies slice [i*512 +: 512]
- core_s_tvalid  out  1  to core input valid
- core_s_tready  in  1  from core input ready
- core_s_tdata  out  C_AXIS_TDATA_WIDTH  muxed spectrum to core
- core_m_tvalid  in  1  core output valid
- core_m_tready  out  1  core output ready
- core_m_tdata  in  C_AXIS_TOUT_WIDTH  core output samples
- m_tvalid  out  NUM_CH  per-channel result valid
- m_tready  in  NUM_CH  per-channel result ready
- m_tdata  out  C_AXIS_TOUT_WIDTH  core_m_tdata broadcast to all channels
- busy  out  1  tag FIFO non-empty
- err_orphan  out  1  sticky: core produced a beat with the tag FIFO empty

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - rr_ptr=0, FIFO wr_ptr=rd_ptr=0, count=0, err_orphan=0.
  - All outputs then evaluate to 0: s_tready, core_s_tvalid, m_tvalid, busy.
  - Reset mid-operation discards all tags. Beats still inside the core are not tracked; the bench resets core and arbiter together.
- Arbitration, combinational within the cycle:
  - grant = first i with s_tvalid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - fifo_full = (count==TAG_DEPTH).
  - core_s_tvalid = |s_tvalid & ~fifo_full.
  - core_s_tdata = slice[grant]. It is 0 when no requester is valid.
  - s_tready[i] = (i==grant) & core_s_tready & ~fifo_full & s_tvalid[i]. At most one bit is set.
- Accept:
  - An accept occurs when core_s_tvalid & core_s_tready.
  - On accept: write grant into the FIFO at wr_ptr, wr_ptr+1, and rr_ptr <= grant+1 modulo NUM_CH (wraps from NUM_CH-1 to 0).
  - With no accept, rr_ptr holds.
  - Zero added latency on the input path.
- Return path:
  - head = fifo[rd_ptr], valid when count>0.
  - m_tvalid[i] = core_m_tvalid & (count>0) & (head==i).
  - core_m_tready = (count>0) ? m_tready[head] : 1. When the FIFO is empty the orphan beat is drained.
  - On pop (core_m_tvalid & core_m_tready & count>0): rd_ptr+1.
  - If core_m_tvalid & count==0: err_orphan <= 1. It stays 1 until reset.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. A pop frees no space in the same cycle, because full is evaluated on the registered count.
- Pointer wrap: wr_ptr and rd_ptr are CH_W-independent log2(TAG_DEPTH)-bit counters and wrap naturally.
- Ordering: results return strictly in grant order. A stalled channel's m_tready=0 blocks all channels; head-of-line blocking is intended.
- busy = (count!=0).
- Fairness: a continuously valid channel waits at most NUM_CH-1 accepts between its own accepts.

Test Plan:
- Single channel: ch2 sends one beat, X0..X7 real=8, imag=0 → granted the same cycle, tag 2 pushed. After 4 core cycles m_tvalid=4'b0100, every sample byte=8'h01 except bytes for x1..x7=0. busy then falls to 0.
- All four channels held valid for 8 accepts, rr_ptr=0 after reset → grant order 0,1,2,3,0,1,2,3. Outputs return on m_tvalid one-hot in the same order.
- Backpressure: m_tready[1]=0 while ch1's result is at head → core_m_tready=0 and the core stalls. Once core_s_tready drops, no further accepts. Releasing m_tready[1] resumes with no lost or duplicated beats.
- Full: hold core_m_tready low externally by m_tready=0 and force core_s_tready=1 via a stub core for 8 accepts → count=8, all s_tready=0. One pop then allows exactly one accept on the next cycle.
- Orphan: stub asserts core_m_tvalid with the FIFO empty → core_m_tready=1, m_tvalid=0, err_orphan=1 from the next cycle until reset.
- Asynchronous reset asserted between clock edges with count=3 → count=0, busy=0 and s_tready=0 without waiting for a clock edge. After release, the first grant goes to the lowest valid channel.

Source files
------------

// File: rtl/axis_ifft_channel_arbiter.sv
// Round-robin front end that shares one IFFT core between NUM_CH AXI-Stream
// channels. One input beat is granted per accept, its channel is queued in an
// in-order tag FIFO, and each core output beat is steered back to the
// channel at the head of that FIFO.
module axis_ifft_channel_arbiter #(
  parameter int NUM_CH             = 4,
  parameter int CH_W               = 2,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_AXIS_TOUT_WIDTH  = 64,
  parameter int TAG_DEPTH          = 8
) (
  input  logic                                 s_axis_aclk,
  input  logic                                 s_axis_areset,
  input  logic [NUM_CH-1:0]                    s_tvalid,
  output logic [NUM_CH-1:0]                    s_tready,
  input  logic [NUM_CH*C_AXIS_TDATA_WIDTH-1:0] s_tdata,
  output logic                                 core_s_tvalid,
  input  logic                                 core_s_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]        core_s_tdata,
  input  logic                                 core_m_tvalid,
  output logic                                 core_m_tready,
  input  logic [C_AXIS_TOUT_WIDTH-1:0]         core_m_tdata,
  output logic [NUM_CH-1:0]                    m_tvalid,
  input  logic [NUM_CH-1:0]                    m_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]         m_tdata,
  output logic                                 busy,
  output logic                                 err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CH_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err_orphan;
  logic [CH_W-1:0]  r_tags [TAG_DEPTH];

  logic [CH_W-1:0]  w_grant;
  logic [CH_W-1:0]  w_rr_next;
  logic [CH_W-1:0]  w_head;
  logic             w_any_valid;
  logic             w_full;
  logic             w_nempty;
  logic             w_accept;
  logic             w_pop;

  // Channel index modulo NUM_CH, for non-power-of-two channel counts.
  function automatic logic [CH_W-1:0] ch_wrap(input int v);
    return CH_W'(v % NUM_CH);
  endfunction

  // Round-robin search from rr_ptr; scanned backwards so the nearest requester wins.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    w_grant     = r_rr_ptr;
    w_any_valid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (s_tvalid[ch_wrap(int'(r_rr_ptr) + k)]) begin
        w_grant     = ch_wrap(int'(r_rr_ptr) + k);
        w_any_valid = 1'b1;
      end
    end
  end

  assign w_full   = (r_count == CNT_W'(TAG_DEPTH));
  assign w_nempty = (r_count != '0);
  assign w_head   = r_tags[r_rd_ptr];

  // Reset gating keeps the request visible to the core low while reset is held.
  assign core_s_tvalid = w_any_valid & ~w_full & ~s_axis_areset;
  assign core_s_tdata  = w_any_valid ?
                         s_tdata[w_grant*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH] : '0;
  assign w_accept      = core_s_tvalid & core_s_tready;
  assign w_rr_next     = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + CH_W'(1);

  // Only the granted channel sees ready, and only when the beat is really taken.
  always_comb begin
    s_tready = '0;
    if (w_accept) s_tready[w_grant] = 1'b1;
  end

  // An empty FIFO means the beat has no owner; drain it rather than stall the core.
  assign core_m_tready = w_nempty ? m_tready[w_head] : 1'b1;
  assign w_pop         = core_m_tvalid & core_m_tready & w_nempty;
  assign m_tdata       = core_m_tdata;
  assign busy          = w_nempty;
  assign err_orphan    = r_err_orphan;

  // Steer the core output valid to the channel that issued the oldest beat.
  always_comb begin
    m_tvalid = '0;
    if (core_m_tvalid & w_nempty) m_tvalid[w_head] = 1'b1;
  end

  // Control state: FIFO pointers and occupancy, round-robin pointer, sticky error.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here sees the pre-edge values.
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_rr_ptr <= w_rr_next;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (core_m_tvalid & ~w_nempty) r_err_orphan <= 1'b1;
    end
  end

  // Tag storage, written on accept.
  always_ff @(posedge s_axis_aclk) begin
    // NOTE: storage is not reset; entries are only read while count marks them valid.
    if (w_accept) r_tags[r_wr_ptr] <= w_grant;
  end

endmodule

// File: tb/tb_axis_ifft_channel_arbiter.sv
// Bench for axis_ifft_channel_arbiter: a stub IFFT core (4-stage whole-stall
// pipeline, or directly driven stub mode) plus a queue-based reference model
// of grants, tags and results checked every cycle.
module tb_axis_ifft_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 512;
  localparam int OW     = 64;
  localparam int DEPTH  = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    s_tvalid;
  logic [NUM_CH-1:0]    s_tready;
  logic [NUM_CH*DW-1:0] s_tdata;
  logic                 core_s_tvalid;
  logic                 core_s_tready;
  logic [DW-1:0]        core_s_tdata;
  logic                 core_m_tvalid;
  logic                 core_m_tready;
  logic [OW-1:0]        core_m_tdata;
  logic [NUM_CH-1:0]    m_tvalid;
  logic [NUM_CH-1:0]    m_tready;
  logic [OW-1:0]        m_tdata;
  logic                 busy;
  logic                 err_orphan;

  // stub controls: when stub=1 the core handshakes are driven directly
  logic                 stub;
  logic                 stub_srdy;
  logic                 stub_mvalid;
  logic [OW-1:0]        stub_mdata;

  int n_err = 0;
  int n_chk = 0;

  // reference model state
  int          m_rr;
  int          m_q[$];
  logic [63:0] m_dq[$];
  bit          m_err;
  bit          f_acc, f_pop, f_orph;
  int          f_grant;
  logic [63:0] f_data;

  always #5 clk = ~clk;

  axis_ifft_channel_arbiter #(
    .NUM_CH(NUM_CH), .CH_W(2), .C_AXIS_TDATA_WIDTH(DW),
    .C_AXIS_TOUT_WIDTH(OW), .TAG_DEPTH(DEPTH)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .core_s_tvalid (core_s_tvalid),
    .core_s_tready (core_s_tready),
    .core_s_tdata  (core_s_tdata),
    .core_m_tvalid (core_m_tvalid),
    .core_m_tready (core_m_tready),
    .core_m_tdata  (core_m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tdata       (m_tdata),
    .busy          (busy),
    .err_orphan    (err_orphan)
  );

  // 8-point IFFT of (re,im) 32-bit signed pairs, real part scaled by 1/64, one byte per sample.
  function automatic logic [63:0] ifft8(input logic [511:0] x);
    logic [63:0]        r;
    real                acc, ang;
    int                 s;
    logic signed [31:0] re_v, im_v;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 0.0;
      for (int k = 0; k < 8; k++) begin
        re_v = x[k*64 +: 32];
        im_v = x[k*64+32 +: 32];
        ang  = 6.283185307179586 * real'(k * n) / 8.0;
        acc  = acc + real'(re_v) * $cos(ang) - real'(im_v) * $sin(ang);
      end
      acc = acc / 64.0;
      s = $rtoi(acc >= 0.0 ? acc + 0.5 : acc - 0.5);
      r[n*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  // stub core: 4-stage pipeline that stalls as a whole on its own output ready
  logic        pv [4];
  logic [63:0] pd [4];
  logic        core_adv;
  assign core_adv      = !pv[3] || core_m_tready;
  assign core_s_tready = stub ? stub_srdy   : core_adv;
  assign core_m_tvalid = stub ? stub_mvalid : pv[3];
  assign core_m_tdata  = stub ? stub_mdata  : pd[3];

  // Stub core pipeline advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
    end else if (!stub && core_adv) begin
      pv[0] <= core_s_tvalid & core_s_tready;
      pd[0] <= ifft8(core_s_tdata);
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_rr = 0;
    m_q.delete();
    m_dq.delete();
    m_err = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH * DW / 32; i++) s_tdata[i*32 +: 32] = $urandom;
  endtask

  // Called just after a falling edge with inputs set: compare DUT against the model.
  task automatic settle();
    logic [NUM_CH-1:0] e_srdy, e_mv;
    logic              e_csv, e_cmr;
    logic [DW-1:0]     e_data;
    int                g, idx;
    bit                full;
    #1;
    g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (m_rr + k) % NUM_CH;
      if (g < 0 && s_tvalid[idx]) g = idx;
    end
    full   = (m_q.size() == DEPTH);
    e_csv  = (g >= 0) && !full;
    e_data = (g >= 0) ? s_tdata[g*DW +: DW] : '0;
    e_srdy = '0;
    if (e_csv && core_s_tready) e_srdy[g] = 1'b1;
    e_cmr  = (m_q.size() > 0) ? m_tready[m_q[0]] : 1'b1;
    e_mv   = '0;
    if (core_m_tvalid && m_q.size() > 0) e_mv[m_q[0]] = 1'b1;
    check("core_s_tvalid", core_s_tvalid, e_csv);
    check("core_s_tdata", core_s_tdata, e_data);
    check("s_tready", s_tready, e_srdy);
    check("core_m_tready", core_m_tready, e_cmr);
    check("m_tvalid", m_tvalid, e_mv);
    check("busy", busy, m_q.size() != 0);
    check("err_orphan", err_orphan, m_err);
    f_acc   = e_csv && core_s_tready;
    f_grant = g;
    f_data  = ifft8(e_data);
    f_pop   = core_m_tvalid && e_cmr && (m_q.size() > 0);
    f_orph  = core_m_tvalid && (m_q.size() == 0);
    if (f_pop && !stub) check("m_tdata_order", m_tdata, m_dq[0]);
    else if (stub && core_m_tvalid) check("m_tdata_bcast", m_tdata, stub_mdata);
  endtask

  // Clock edge: apply the model's accept/pop/orphan decisions, return at the next falling edge.
  task automatic advance();
    @(posedge clk);
    if (f_acc) begin
      m_q.push_back(f_grant);
      m_dq.push_back(f_data);
      m_rr = (f_grant + 1) % NUM_CH;
    end
    if (f_pop) begin
      void'(m_q.pop_front());
      void'(m_dq.pop_front());
    end
    if (f_orph) m_err = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_CH-1:0] exp_oh;
    rst = 1'b1; s_tvalid = '0; s_tdata = '0; m_tready = '0;
    stub = 1'b0; stub_srdy = 1'b0; stub_mvalid = 1'b0; stub_mdata = '0;
    mdl_reset();

    // reset state, with requests present
    s_tvalid = 4'hF; m_tready = 4'hF;
    @(negedge clk); #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_core_s_tvalid", core_s_tvalid, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_orphan", err_orphan, 0);
    @(negedge clk);
    rst = 1'b0; s_tvalid = '0;

    // single channel: ch2, X0..X7 real=8 imag=0 -> x0 byte 01, rest 0
    s_tdata = '0;
    for (int k = 0; k < 8; k++) s_tdata[2*DW + k*64 +: 32] = 32'd8;
    s_tvalid = 4'b0100;
    settle(); check("single_grant", s_tready, 4'b0100); advance();
    s_tvalid = '0;
    repeat (3) begin settle(); advance(); end
    settle();
    check("single_m_tvalid", m_tvalid, 4'b0100);
    check("single_m_tdata", m_tdata, 64'h0000_0000_0000_0001);
    advance();
    settle(); check("single_idle", busy, 0); advance();

    // round robin: all valid from rr_ptr=0
    do_reset();
    s_tvalid = 4'hF; m_tready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      exp_oh = 4'(1 << (i % 4));
      settle(); check($sformatf("rr_grant%0d", i), s_tready, exp_oh); advance();
    end
    s_tvalid = '0;
    repeat (8) begin settle(); advance(); end
    settle(); check("rr_drained", busy, 0); advance();

    // backpressure on ch1 stalls the whole core
    s_tvalid = 4'hF; m_tready = 4'b1101;
    repeat (20) begin rand_data(); settle(); advance(); end
    settle();
    check("bp_core_m_tready", core_m_tready, 0);
    check("bp_no_accept", s_tready, 0);
    advance();
    m_tready = 4'hF; s_tvalid = '0;
    repeat (10) begin settle(); advance(); end
    settle(); check("bp_drained", busy, 0); advance();

    // randomized traffic with random backpressure
    repeat (200) begin
      s_tvalid = 4'($urandom);
      m_tready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rand_data();
      settle(); advance();
    end
    s_tvalid = '0; m_tready = 4'hF;
    repeat (12) begin settle(); advance(); end
    settle(); check("rand_drained", busy, 0); advance();

    // full: stub core always ready, results blocked
    stub = 1'b1; stub_srdy = 1'b1; stub_mvalid = 1'b0; m_tready = '0; s_tvalid = 4'hF;
    repeat (8) begin rand_data(); settle(); advance(); end
    settle();
    check("full_s_tready", s_tready, 0);
    check("full_core_s_tvalid", core_s_tvalid, 0);
    check("full_busy", busy, 1);
    advance();
    stub_mvalid = 1'b1; stub_mdata = {$urandom, $urandom}; m_tready = 4'hF;
    settle();
    check("full_pop_ready", core_m_tready, 1);
    check("full_no_same_cycle", s_tready, 0);
    advance();
    stub_mvalid = 1'b0;
    settle(); check("full_one_accept", |s_tready, 1); advance();
    settle(); check("full_again", s_tready, 0); advance();

    // orphan beat with the FIFO empty
    do_reset();
    s_tvalid = '0; stub_srdy = 1'b0; stub_mvalid = 1'b1;
    settle();
    check("orph_core_m_tready", core_m_tready, 1);
    check("orph_m_tvalid", m_tvalid, 0);
    check("orph_not_yet", err_orphan, 0);
    advance();
    stub_mvalid = 1'b0;
    repeat (3) begin settle(); check("orph_sticky", err_orphan, 1); advance(); end

    // asynchronous reset between edges with three tags outstanding
    do_reset();
    stub_srdy = 1'b1; m_tready = '0; s_tvalid = 4'hF;
    repeat (3) begin rand_data(); settle(); advance(); end
    s_tvalid = '0;
    settle(); check("ar_busy_before", busy, 1);
    s_tvalid = 4'b1010;
    #1 rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_s_tready", s_tready, 0);
    check("ar_core_s_tvalid", core_s_tvalid, 0);
    check("ar_m_tvalid", m_tvalid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    settle(); check("ar_first_grant", s_tready, 4'b0010); advance();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
